// File: rtl/rfphoenix_icmiss.sv
// rfphoenix_icmiss: I-cache miss handler and line-fill engine.
//
// Takes the registered hit flag from the hit detector, and on a miss for the
// fetch address presented two cycles earlier it does three things:
//   - picks a victim way round-robin,
//   - bursts the 64-byte line in over four bus beats,
//   - issues a single cache-line write strobe.
// It also owns the per-way valid bit arrays that the hit detector reads.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   ip, ip_valid    fetch address and its qualifier
//   ihit            hit result aligned with ip delayed by two cycles
//   invall          clear every valid bit
//   invline         clear valid bits of all ways at index inv_adr[12:6]
//   inv_adr         invalidate address
//   valid           valid[way][ndx] bit arrays
//   miss            handler busy, fetch stalls
//   wr              one-cycle cache write strobe
//   wway/wndx/wtag  write way, line index and tag
//   wline           assembled line data
//   cyc/stb/adr     bus master request
//   ack/err/dat_i   bus response
//   fill_err        one-cycle pulse when a fill is aborted by a bus error
//
// state  | meaning
// IDLE   | watching for ipv_d2 && !ihit
// FETCH  | bursting four beats from the bus
// WRITE  | line complete, write strobe and valid set issued on exit
// SETTLE | three-cycle blanking so the hit pipeline sees the new line
module rfphoenix_icmiss #(
    parameter int AWID      = 32,
    parameter int LINES     = 128,
    parameter int WAYS      = 4,
    parameter int LINE_BITS = 512,
    parameter int BUS_BITS  = 128
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [AWID-1:0]                   ip,
    input  logic                              ip_valid,
    input  logic                              ihit,
    input  logic                              invall,
    input  logic                              invline,
    input  logic [AWID-1:0]                   inv_adr,
    output logic [WAYS-1:0][LINES-1:0]        valid,
    output logic                              miss,
    output logic                              wr,
    output logic [$clog2(WAYS)-1:0]           wway,
    output logic [$clog2(LINES)-1:0]          wndx,
    output logic [AWID-8:0]                   wtag,
    output logic [LINE_BITS-1:0]              wline,
    output logic                              cyc,
    output logic                              stb,
    output logic [AWID-1:0]                   adr,
    input  logic                              ack,
    input  logic                              err,
    input  logic [BUS_BITS-1:0]               dat_i,
    output logic                              fill_err
);

    localparam int NW = $clog2(LINES);
    localparam int WW = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, SETTLE} state_t;

    state_t          state, state_nx;
    logic [AWID-1:6] ip_d1, ip_d2;
    logic            ipv_d1, ipv_d2;
    logic [AWID-1:6] line_adr;
    logic [1:0]      beat;
    logic [1:0]      settle_cnt;
    logic [WW-1:0]   victim;
    logic            start, take, abort, commit;

    // Address bits below the line offset and above the index of inv_adr
    // carry no information for this block.
    logic unused_ok;
    assign unused_ok = ^{ip[5:0], inv_adr[AWID-1:6+NW], inv_adr[5:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        take     = 1'b0;
        abort    = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (ipv_d2 && !ihit) begin
                    start    = 1'b1;
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                // err outranks a simultaneous ack
                if (err) begin
                    abort    = 1'b1;
                    state_nx = SETTLE;
                end else if (ack) begin
                    take = 1'b1;
                    if (beat == 2'd3) state_nx = WRITE;
                end
            end
            WRITE: begin
                commit   = 1'b1;
                state_nx = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == 2'd0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ip_d1      <= '0;
            ip_d2      <= '0;
            ipv_d1     <= 1'b0;
            ipv_d2     <= 1'b0;
            line_adr   <= '0;
            beat       <= 2'd0;
            settle_cnt <= 2'd0;
            victim     <= '0;
            miss       <= 1'b0;
            wr         <= 1'b0;
            wway       <= '0;
            wndx       <= '0;
            wtag       <= '0;
            wline      <= '0;
            cyc        <= 1'b0;
            stb        <= 1'b0;
            adr        <= '0;
            fill_err   <= 1'b0;
            valid      <= '0;
        end else begin
            ip_d1    <= ip[AWID-1:6];
            ip_d2    <= ip_d1;
            ipv_d1   <= ip_valid;
            ipv_d2   <= ipv_d1;
            wr       <= commit;
            fill_err <= abort;

            if (start) begin
                line_adr <= ip_d2;
                wway     <= victim;
                wndx     <= ip_d2[6+NW-1:6];
                wtag     <= ip_d2[AWID-1:7];
                beat     <= 2'd0;
                cyc      <= 1'b1;
                stb      <= 1'b1;
                adr      <= {ip_d2, 6'h00};
                miss     <= 1'b1;
            end

            if (take) begin
                wline[beat*BUS_BITS +: BUS_BITS] <= dat_i;
                beat <= beat + 2'd1;
                adr  <= {line_adr, beat + 2'd1, 4'h0};
                if (beat == 2'd3) begin
                    cyc <= 1'b0;
                    stb <= 1'b0;
                end
            end

            if (abort) begin
                cyc        <= 1'b0;
                stb        <= 1'b0;
                settle_cnt <= 2'd2;
            end

            if (commit) begin
                victim     <= victim + 1'b1;
                settle_cnt <= 2'd2;
            end

            // Blanking timer: counts 2,1,0 then releases miss as IDLE is entered.
            if (state == SETTLE) begin
                if (settle_cnt != 2'd0) settle_cnt <= settle_cnt - 2'd1;
                else                    miss <= 1'b0;
            end

            // Invalidation is applied after the set so it wins a same-cycle race.
            if (commit) valid[wway][wndx] <= 1'b1;
            if (invall) begin
                valid <= '0;
            end else if (invline) begin
                for (int w = 0; w < WAYS; w++)
                    valid[w][inv_adr[6+NW-1:6]] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rfphoenix_icmiss.sv
module tb_rfphoenix_icmiss;

    logic                clk;
    logic                rst;
    logic [31:0]         ip;
    logic                ip_valid;
    logic                ihit;
    logic                invall;
    logic                invline;
    logic [31:0]         inv_adr;
    logic [3:0][127:0]   valid;
    logic                miss;
    logic                wr;
    logic [1:0]          wway;
    logic [6:0]          wndx;
    logic [24:0]         wtag;
    logic [511:0]        wline;
    logic                cyc;
    logic                stb;
    logic [31:0]         adr;
    logic                ack;
    logic                err;
    logic [127:0]        dat_i;
    logic                fill_err;

    rfphoenix_icmiss dut (
        .clk(clk), .rst(rst), .ip(ip), .ip_valid(ip_valid), .ihit(ihit),
        .invall(invall), .invline(invline), .inv_adr(inv_adr), .valid(valid),
        .miss(miss), .wr(wr), .wway(wway), .wndx(wndx), .wtag(wtag),
        .wline(wline), .cyc(cyc), .stb(stb), .adr(adr), .ack(ack), .err(err),
        .dat_i(dat_i), .fill_err(fill_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: valid bits and victim pointer, updated from the
    // externally visible events (completed fill, invalidations, reset).
    logic [3:0][127:0] valid_m;
    logic [1:0]        victim_m;

    typedef struct {
        logic [31:0] addr;
        int          err_beat;
        int          inv_mode;   // 0 none, 1 invline at inv_a, 2 invall (in WRITE cycle)
        logic [31:0] inv_a;
        logic        exp_wr;
        logic [1:0]  exp_way;
        logic [6:0]  exp_ndx;
        logic        exp_vbit;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_fill(input logic [31:0] addr, input int err_beat, input int inv_mode,
                           input logic [31:0] inv_a, input int max_wait,
                           output logic got_wr, output logic [1:0] got_way,
                           output logic [6:0] got_ndx, output logic got_vbit);
        logic [127:0] beats [4];
        logic [511:0] exp_line;
        logic [1:0]   exp_way;
        logic [6:0]   ndx;
        int           nw;
        exp_way  = victim_m;
        ndx      = addr[12:6];
        got_wr   = 1'b0;
        got_way  = 2'd0;
        got_ndx  = 7'd0;
        got_vbit = 1'b0;
        ip = addr; ip_valid = 1'b1; ihit = 1'b0;
        tick();
        ip_valid = 1'b0;
        tick();
        chk("miss_before_detect", 512'(miss), 512'(1'b0));
        tick();
        chk("first_stb", 512'({cyc, stb, miss}), 512'(3'b111));
        for (int b = 0; b < 4; b++) begin
            nw = int'($urandom_range(0, max_wait));
            for (int i = 0; i < nw; i++) begin
                chk("stb_hold", 512'({cyc, stb, miss}), 512'(3'b111));
                tick();
            end
            chk("adr", 512'(adr), 512'({addr[31:6], b[1:0], 4'h0}));
            if (b == err_beat) begin
                err = 1'b1;
                if ($urandom_range(0, 1) == 1) ack = 1'b1;
                tick();
                err = 1'b0; ack = 1'b0;
                chk("err_drop", 512'({cyc, stb, wr, fill_err}), 512'(4'b0001));
                tick();
                chk("err_pulse_once", 512'({fill_err, wr, miss}), 512'(3'b001));
                tick();
                chk("err_settle", 512'({wr, miss}), 512'(2'b01));
                tick();
                chk("err_idle", 512'({miss, cyc}), 512'(2'b00));
                chk("err_valid", 512'(valid), 512'(valid_m));
                return;
            end
            beats[b] = {$urandom, $urandom, $urandom, $urandom};
            ack = 1'b1; dat_i = beats[b];
            tick();
            ack = 1'b0; dat_i = {$urandom, $urandom, $urandom, $urandom};
        end
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        chk("write_cycle", 512'({cyc, stb, wr, miss}), 512'(4'b0001));
        valid_m[exp_way][ndx] = 1'b1;
        if (inv_mode == 1) begin
            invline = 1'b1; inv_adr = inv_a;
            for (int w = 0; w < 4; w++) valid_m[w][inv_a[12:6]] = 1'b0;
        end else if (inv_mode == 2) begin
            invall = 1'b1;
            valid_m = '0;
        end
        victim_m = victim_m + 2'd1;
        tick();
        invline = 1'b0; invall = 1'b0;
        got_wr = wr; got_way = wway; got_ndx = wndx; got_vbit = valid[wway][wndx];
        chk("wr", 512'(wr), 512'(1'b1));
        chk("wway", 512'(wway), 512'(exp_way));
        chk("wndx", 512'(wndx), 512'(ndx));
        chk("wtag", 512'(wtag), 512'(addr[31:7]));
        chk("wline", wline, exp_line);
        chk("valid", 512'(valid), 512'(valid_m));
        // A missing fetch during blanking must be ignored.
        ip = addr ^ 32'h0000_0040; ip_valid = 1'b1; ihit = 1'b0;
        tick();
        ip_valid = 1'b0;
        chk("wr_once", 512'({wr, miss}), 512'(2'b01));
        tick();
        chk("settle_miss", 512'({miss, cyc}), 512'(2'b10));
        tick();
        chk("settle_exit", 512'({miss, cyc}), 512'(2'b00));
        tick();
        chk("no_refill", 512'({miss, cyc, wr}), 512'(3'b000));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        g_wr, g_vbit;
        logic [1:0]  g_way;
        logic [6:0]  g_ndx;
        logic [31:0] a, ia;
        int          eb, im;

        vecs[0] = '{32'h0000_1040, -1, 0, 32'h0,          1'b1, 2'd0, 7'h41, 1'b1};
        vecs[1] = '{32'h0000_2080, -1, 0, 32'h0,          1'b1, 2'd1, 7'h02, 1'b1};
        vecs[2] = '{32'h0000_30C0, -1, 0, 32'h0,          1'b1, 2'd2, 7'h43, 1'b1};
        vecs[3] = '{32'h0000_4100, -1, 0, 32'h0,          1'b1, 2'd3, 7'h04, 1'b1};
        vecs[4] = '{32'h0000_5140, -1, 0, 32'h0,          1'b1, 2'd0, 7'h45, 1'b1};
        vecs[5] = '{32'h0000_6180,  2, 0, 32'h0,          1'b0, 2'd0, 7'h00, 1'b0};
        vecs[6] = '{32'h0000_71C0, -1, 1, 32'h0000_71C0,  1'b1, 2'd1, 7'h47, 1'b0};
        vecs[7] = '{32'h0000_8200, -1, 1, 32'h0000_1040,  1'b1, 2'd2, 7'h08, 1'b1};
        vecs[8] = '{32'h0000_9240, -1, 2, 32'h0,          1'b1, 2'd3, 7'h49, 1'b0};

        rst = 1'b1; ip = '0; ip_valid = 1'b0; ihit = 1'b0; invall = 1'b0; invline = 1'b0;
        inv_adr = '0; ack = 1'b0; err = 1'b0; dat_i = '0;
        valid_m = '0; victim_m = 2'd0;
        tick(); tick(); tick();
        rst = 1'b0;
        chk("rst_ctrl", 512'({miss, wr, cyc, stb, fill_err}), 512'(5'b0));
        chk("rst_adr", 512'(adr), 512'(0));
        chk("rst_wfields", 512'({wway, wndx, wtag}), 512'(0));
        chk("rst_wline", wline, 512'(0));
        chk("rst_valid", 512'(valid), 512'(0));

        for (int v = 0; v < 9; v++) begin
            do_fill(vecs[v].addr, vecs[v].err_beat, vecs[v].inv_mode, vecs[v].inv_a, 0,
                    g_wr, g_way, g_ndx, g_vbit);
            chk("tbl_wr", 512'(g_wr), 512'(vecs[v].exp_wr));
            if (vecs[v].exp_wr) begin
                chk("tbl_way", 512'(g_way), 512'(vecs[v].exp_way));
                chk("tbl_ndx", 512'(g_ndx), 512'(vecs[v].exp_ndx));
                chk("tbl_vbit", 512'(g_vbit), 512'(vecs[v].exp_vbit));
            end
        end
        chk("tbl_other_line_cleared", 512'({valid[0][65], valid[1][65], valid[2][65], valid[3][65]}), 512'(4'b0));

        // Hit path and ip_valid low: the bus must stay quiet.
        ip = 32'h0000_A000; ip_valid = 1'b1; ihit = 1'b1;
        for (int i = 0; i < 6; i++) begin chk("hit_quiet", 512'({cyc, miss}), 512'(2'b00)); tick(); end
        ip_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin chk("hit_drain", 512'({cyc, miss}), 512'(2'b00)); tick(); end
        ihit = 1'b0;
        for (int i = 0; i < 4; i++) begin chk("ipv_low_quiet", 512'({cyc, miss}), 512'(2'b00)); tick(); end

        // Invalidate all while idle.
        do_fill(32'h0000_B2C0, -1, 0, 32'h0, 1, g_wr, g_way, g_ndx, g_vbit);
        invall = 1'b1; tick(); invall = 1'b0;
        valid_m = '0;
        chk("invall_idle", 512'(valid), 512'(valid_m));

        // Reset in the middle of a burst, right after the beat-1 ack.
        ip = 32'h0000_C300; ip_valid = 1'b1; ihit = 1'b0;
        tick(); ip_valid = 1'b0; tick(); tick();
        ack = 1'b1; dat_i = {4{$urandom}}; tick();
        ack = 1'b1; dat_i = {4{$urandom}}; tick();
        ack = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_drop", 512'({cyc, stb, miss}), 512'(3'b000));
        valid_m = '0; victim_m = 2'd0;
        for (int i = 0; i < 8; i++) begin
            chk("rst_mid_no_wr", 512'({wr, cyc}), 512'(2'b00));
            tick();
        end
        chk("rst_mid_valid", 512'(valid), 512'(0));
        do_fill(32'h0000_D340, -1, 0, 32'h0, 0, g_wr, g_way, g_ndx, g_vbit);
        chk("rst_mid_way0", 512'(g_way), 512'(2'd0));

        // Randomized fills on a small set of indices so invalidates collide.
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            a[12:6] = 7'($urandom_range(0, 7));
            eb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            im = int'($urandom_range(0, 3));
            if (im == 3) im = 0;
            ia = $urandom;
            if ($urandom_range(0, 1) == 1) ia[12:6] = a[12:6];
            else ia[12:6] = 7'($urandom_range(0, 7));
            do_fill(a, eb, im, ia, 2, g_wr, g_way, g_ndx, g_vbit);
            if ($urandom_range(0, 3) == 0) begin
                ia = $urandom;
                ia[12:6] = 7'($urandom_range(0, 7));
                invline = 1'b1; inv_adr = ia;
                for (int w = 0; w < 4; w++) valid_m[w][ia[12:6]] = 1'b0;
                tick();
                invline = 1'b0;
                chk("rnd_invline", 512'(valid), 512'(valid_m));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
